// File: rtl/pc_fetch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pc_fetch_ctrl_pkg
// Shared definitions for the fetch program-counter controller: default
// address width and reset vector, FSM state codes and a small state decode
// helper.
// ---------------------------------------------------------------------------
package pc_fetch_ctrl_pkg;

  localparam int          DEFAULT_XLEN         = 64;
  localparam logic [63:0] DEFAULT_RESET_VECTOR = 64'h0;

  // FSM state codes (kept as plain constants so legacy code can match them).
  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_PEND = 2'd2;
  localparam logic [1:0] ST_HALT = 2'd3;

  // Named view of the same encoding, for waveform viewers and debug code.
  typedef enum logic [1:0] {
    FS_BOOT = 2'd0,
    FS_RUN  = 2'd1,
    FS_PEND = 2'd2,
    FS_HALT = 2'd3
  } fetch_state_e;

  // True in the states that are allowed to present a fetch request.
  function automatic logic is_fetching(input logic [1:0] st);
    logic r;
    case (st)
      ST_RUN:  r = 1'b1;
      ST_PEND: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// pc_fetch_ctrl_if
// Instruction-memory request channel (valid/ready handshake).
//   req_valid : request valid        (master -> slave)
//   req_addr  : fetch address, N bit (master -> slave)
//   req_ready : memory accepts       (slave  -> master)
// ---------------------------------------------------------------------------
interface pc_fetch_ctrl_if #(
  parameter int N = 64
);
  logic         req_valid;
  logic [N-1:0] req_addr;
  logic         req_ready;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready
  );
endinterface

// File: rtl/pc_fetch_ctrl_target_sel.sv
// ---------------------------------------------------------------------------
// pc_fetch_ctrl_target_sel
// Combinational target priority mux for the fetch controller.
// Chooses between a new trap, a new redirect and the parked pending target:
//   - a trap always wins,
//   - a redirect wins unless the parked entry is itself a trap,
//   - otherwise the parked entry is kept.
// Also produces the aligned version of the chosen target and a flag telling
// whether the raw target had any low (sub-instruction) bits set.
// Ports:
//   trap_valid_i/trap_pc_i          new trap request
//   redirect_valid_i/redirect_pc_i  new branch/jump redirect
//   pend_valid_i/pend_trap_i/pend_pc_i  parked pending slot
//   sel_trap_o      chosen entry is a trap (for slot bookkeeping)
//   sel_raw_o       chosen target as received (stored in the slot)
//   sel_pc_o        chosen target with low bits cleared (loaded into pc)
//   sel_misalign_o  chosen target had nonzero low bits
// ---------------------------------------------------------------------------
module pc_fetch_ctrl_target_sel #(
  parameter int N           = 64,
  parameter int INSTR_BYTES = 4
) (
  input  logic         trap_valid_i,
  input  logic [N-1:0] trap_pc_i,
  input  logic         redirect_valid_i,
  input  logic [N-1:0] redirect_pc_i,
  input  logic         pend_valid_i,
  input  logic         pend_trap_i,
  input  logic [N-1:0] pend_pc_i,
  output logic         sel_trap_o,
  output logic [N-1:0] sel_raw_o,
  output logic [N-1:0] sel_pc_o,
  output logic         sel_misalign_o
);

  // Low address bits that must be zero for an instruction-aligned PC.
  localparam logic [N-1:0] LOW_MASK = N'(INSTR_BYTES - 1);

  // Priority selection: trap > redirect (unless a trap is parked) > parked.
  always_comb begin
    sel_trap_o = 1'b0;
    sel_raw_o  = redirect_pc_i;
    if (trap_valid_i) begin
      sel_trap_o = 1'b1;
      sel_raw_o  = trap_pc_i;
    end else if (redirect_valid_i && !(pend_valid_i && pend_trap_i)) begin
      sel_trap_o = 1'b0;
      sel_raw_o  = redirect_pc_i;
    end else if (pend_valid_i) begin
      sel_trap_o = pend_trap_i;
      sel_raw_o  = pend_pc_i;
    end else begin
      sel_trap_o = 1'b0;
      sel_raw_o  = redirect_pc_i;
    end
  end

  assign sel_pc_o       = sel_raw_o & ~LOW_MASK;
  assign sel_misalign_o = |(sel_raw_o & LOW_MASK);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// pc_fetch_ctrl
// Front-of-IF program counter. Holds the fetch PC, presents it to
// instruction memory over a valid/ready channel, advances by INSTR_BYTES on
// every accepted request and applies traps/redirects by priority. While a
// request is held by a stalling memory, a late redirect/trap is parked in a
// one-entry pending slot so that the presented address never changes.
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   enable_i            0 = do not raise a new request, pc holds
//   halt_req_i          stop fetching once no request is held
//   trap_valid_i/_pc_i  trap entry, highest priority
//   redirect_valid_i/_pc_i  branch/jump correction
//   mem_if (master)     req_valid / req_addr / req_ready
//   fetch_kill_o        instruction accepted this cycle must be dropped
//   misalign_o          one-cycle pulse after loading a misaligned target
//   pc_out_o            current pc (same as req_addr)
//   halted_o            controller is in HALT
// ---------------------------------------------------------------------------
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int           N            = DEFAULT_XLEN,
  parameter logic [N-1:0] RESET_VECTOR = N'(DEFAULT_RESET_VECTOR),
  parameter int           INSTR_BYTES  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable_i,
  input  logic                   halt_req_i,
  input  logic                   trap_valid_i,
  input  logic [N-1:0]           trap_pc_i,
  input  logic                   redirect_valid_i,
  input  logic [N-1:0]           redirect_pc_i,
  pc_fetch_ctrl_if.master        mem_if,
  output logic                   fetch_kill_o,
  output logic                   misalign_o,
  output logic [N-1:0]           pc_out_o,
  output logic                   halted_o
);

  localparam logic [N-1:0] STEP = N'(INSTR_BYTES);

  logic [1:0]   state_q, state_d;
  logic [N-1:0] pc_q, pc_d;
  logic         held_q, held_d;
  logic         pend_valid_q, pend_valid_d;
  logic         pend_trap_q, pend_trap_d;
  logic [N-1:0] pend_pc_q, pend_pc_d;
  logic         misalign_q, misalign_d;

  logic         req_valid;
  logic         accept;
  logic         evt;
  logic         fetch_kill;

  logic         sel_trap;
  logic [N-1:0] sel_raw;
  logic [N-1:0] sel_pc;
  logic         sel_misalign;

  pc_fetch_ctrl_target_sel #(
    .N           (N),
    .INSTR_BYTES (INSTR_BYTES)
  ) u_target_sel (
    .trap_valid_i     (trap_valid_i),
    .trap_pc_i        (trap_pc_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .pend_valid_i     (pend_valid_q),
    .pend_trap_i      (pend_trap_q),
    .pend_pc_i        (pend_pc_q),
    .sel_trap_o       (sel_trap),
    .sel_raw_o        (sel_raw),
    .sel_pc_o         (sel_pc),
    .sel_misalign_o   (sel_misalign)
  );

  // A raised request stays up until accepted, even if enable drops.
  assign req_valid = is_fetching(state_q) & (enable_i | held_q);
  assign accept    = req_valid & mem_if.req_ready;
  assign evt       = trap_valid_i | redirect_valid_i;

  // Next-state, pc and pending-slot logic.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_valid_d = pend_valid_q;
    pend_trap_d  = pend_trap_q;
    pend_pc_d    = pend_pc_q;
    misalign_d   = 1'b0;
    fetch_kill   = 1'b0;

    if (accept) begin
      held_d = 1'b0;
    end else if (req_valid && !mem_if.req_ready) begin
      held_d = 1'b1;
    end else begin
      held_d = held_q;
    end

    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
        if (evt) begin
          pc_d       = sel_pc;
          misalign_d = sel_misalign;
        end else begin
          pc_d = pc_q;
        end
      end

      ST_RUN: begin
        if (evt && (!held_q || accept)) begin
          // Apply at once; an instruction accepted now is on the wrong path.
          pc_d       = sel_pc;
          misalign_d = sel_misalign;
          fetch_kill = accept;
        end else if (evt) begin
          // Request is held: park the target, keep the address stable.
          pend_valid_d = 1'b1;
          pend_trap_d  = sel_trap;
          pend_pc_d    = sel_raw;
          state_d      = ST_PEND;
        end else if (accept) begin
          pc_d = pc_q + STEP;
        end else if (halt_req_i && !held_q) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_RUN;
        end
      end

      ST_PEND: begin
        if (accept) begin
          // sel_* already folds in any event arriving in this cycle.
          fetch_kill   = 1'b1;
          pc_d         = sel_pc;
          misalign_d   = sel_misalign;
          pend_valid_d = 1'b0;
          pend_trap_d  = 1'b0;
          state_d      = ST_RUN;
        end else begin
          pend_trap_d = sel_trap;
          pend_pc_d   = sel_raw;
        end
      end

      ST_HALT: begin
        if (evt) begin
          pc_d       = sel_pc;
          misalign_d = sel_misalign;
          state_d    = ST_RUN;
        end else begin
          state_d = ST_HALT;
        end
      end

      default: begin
        state_d      = ST_BOOT;
        pend_valid_d = 1'b0;
        pend_trap_d  = 1'b0;
      end
    endcase
  end

  // State, pc, handshake and pending-slot registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_VECTOR;
      held_q       <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_trap_q  <= 1'b0;
      pend_pc_q    <= {N{1'b0}};
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      held_q       <= held_d;
      pend_valid_q <= pend_valid_d;
      pend_trap_q  <= pend_trap_d;
      pend_pc_q    <= pend_pc_d;
      misalign_q   <= misalign_d;
    end
  end

  assign mem_if.req_valid = req_valid;
  assign mem_if.req_addr  = pc_q;
  assign pc_out_o         = pc_q;
  assign fetch_kill_o     = fetch_kill;
  assign misalign_o       = misalign_q;
  assign halted_o         = (state_q == ST_HALT);

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_ctrl
// Self-checking bench for pc_fetch_ctrl (N=64, RESET_VECTOR=0, 4-byte step).
// A behavioural model tracks pc, the held flag, a pending-target queue and
// boot/halt flags; every cycle the DUT outputs are compared against it.
// Directed sequences add hand-computed literal checks.
// ---------------------------------------------------------------------------
module tb_pc_fetch_ctrl;

  localparam int          N  = 64;
  localparam logic [63:0] RV = 64'h0;
  localparam int          IB = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enable_i = 1'b0;
  logic         halt_req_i = 1'b0;
  logic         trap_valid_i = 1'b0;
  logic [N-1:0] trap_pc_i = 64'h0;
  logic         redirect_valid_i = 1'b0;
  logic [N-1:0] redirect_pc_i = 64'h0;
  logic         fetch_kill_o;
  logic         misalign_o;
  logic [N-1:0] pc_out_o;
  logic         halted_o;

  pc_fetch_ctrl_if #(.N(N)) mem_if ();

  pc_fetch_ctrl #(.N(N), .RESET_VECTOR(RV), .INSTR_BYTES(IB)) dut (
    .clk              (clk),
    .rst              (rst),
    .enable_i         (enable_i),
    .halt_req_i       (halt_req_i),
    .trap_valid_i     (trap_valid_i),
    .trap_pc_i        (trap_pc_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .mem_if           (mem_if),
    .fetch_kill_o     (fetch_kill_o),
    .misalign_o       (misalign_o),
    .pc_out_o         (pc_out_o),
    .halted_o         (halted_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        trap;
    logic [63:0] addr;
  } slot_t;

  logic [63:0] m_pc;
  logic        m_held, m_boot, m_halt, m_mis;
  slot_t       m_pend[$];

  function automatic logic [63:0] align(input logic [63:0] a);
    return a - (a % 64'(IB));
  endfunction

  function automatic logic misal(input logic [63:0] a);
    return (a % 64'(IB)) != 64'h0;
  endfunction

  task automatic model_reset();
    m_pc = RV; m_held = 1'b0; m_boot = 1'b1; m_halt = 1'b0; m_mis = 1'b0;
    m_pend.delete();
  endtask

  function automatic logic m_req_valid();
    return !m_boot && !m_halt && (enable_i || m_held);
  endfunction

  function automatic logic m_kill();
    logic acc;
    acc = m_req_valid() && mem_if.req_ready;
    if (m_pend.size() != 0) return acc;
    return acc && (trap_valid_i || redirect_valid_i);
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    logic        rv, acc, ev;
    logic [63:0] tgt;
    slot_t       c;
    rv  = m_req_valid();
    acc = rv && mem_if.req_ready;
    ev  = trap_valid_i || redirect_valid_i;
    tgt = trap_valid_i ? trap_pc_i : redirect_pc_i;
    m_mis = 1'b0;
    if (m_boot) begin
      m_boot = 1'b0;
      if (ev) begin m_pc = align(tgt); m_mis = misal(tgt); end
    end else if (m_halt) begin
      if (ev) begin m_pc = align(tgt); m_mis = misal(tgt); m_halt = 1'b0; end
    end else if (m_pend.size() != 0) begin
      c = m_pend[0];
      if (trap_valid_i) c = '{trap: 1'b1, addr: trap_pc_i};
      else if (redirect_valid_i && !c.trap) c = '{trap: 1'b0, addr: redirect_pc_i};
      if (acc) begin
        m_pc = align(c.addr); m_mis = misal(c.addr); m_pend.delete();
      end else begin
        m_pend[0] = c;
      end
    end else begin
      if (ev && (!m_held || acc)) begin
        m_pc = align(tgt); m_mis = misal(tgt);
      end else if (ev) begin
        m_pend.push_back('{trap: trap_valid_i, addr: tgt});
      end else if (acc) begin
        m_pc = m_pc + 64'(IB);
      end else if (halt_req_i && !m_held) begin
        m_halt = 1'b1;
      end
    end
    if (acc) m_held = 1'b0;
    else if (rv && !mem_if.req_ready) m_held = 1'b1;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("req_valid",  64'(mem_if.req_valid), 64'(m_req_valid()));
    chk("req_addr",   mem_if.req_addr,       m_pc);
    chk("pc_out",     pc_out_o,              m_pc);
    chk("fetch_kill", 64'(fetch_kill_o),     64'(m_kill()));
    chk("misalign",   64'(misalign_o),       64'(m_mis));
    chk("halted",     64'(halted_o),         64'(m_halt));
  endtask

  // One clock: drive at negedge, compare mid-cycle, advance the model.
  task automatic step(input logic r, input logic en, input logic hq,
                      input logic tv, input logic [63:0] tp,
                      input logic rv, input logic [63:0] rp, input logic rdy);
    @(negedge clk);
    rst = r; enable_i = en; halt_req_i = hq;
    trap_valid_i = tv; trap_pc_i = tp;
    redirect_valid_i = rv; redirect_pc_i = rp;
    mem_if.req_ready = rdy;
    #2;
    if (r) model_reset();
    compare_all();
    if (!r) model_step();
  endtask

  // Shorthand for an event-free cycle.
  task automatic idle(input logic en, input logic rdy);
    step(1'b0, en, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, rdy);
  endtask

  task automatic redir(input logic en, input logic [63:0] a, input logic rdy);
    step(1'b0, en, 1'b0, 1'b0, 64'h0, 1'b1, a, rdy);
  endtask

  initial begin
    logic r, en, hq, tv, rv, rdy;
    logic [63:0] tp, rp;
    mem_if.req_ready = 1'b0;
    model_reset();

    // Reset state.
    step(1'b1, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
    chk("rst_pc", pc_out_o, 64'h0);
    chk("rst_valid", 64'(mem_if.req_valid), 64'h0);

    // BOOT then sequential fetch with memory always ready.
    idle(1'b1, 1'b1);
    chk("boot_valid", 64'(mem_if.req_valid), 64'h0);
    idle(1'b1, 1'b1); chk("seq_0", mem_if.req_addr, 64'h0);
    idle(1'b1, 1'b1); chk("seq_4", mem_if.req_addr, 64'h4);
    idle(1'b1, 1'b1); chk("seq_8", mem_if.req_addr, 64'h8);
    idle(1'b1, 1'b1); chk("seq_c", mem_if.req_addr, 64'hC);
    chk("seq_kill", 64'(fetch_kill_o), 64'h0);

    // Memory stall at 0x10, enable dropped mid-stall.
    idle(1'b1, 1'b0);
    idle(1'b0, 1'b0);
    chk("stall_valid", 64'(mem_if.req_valid), 64'h1);
    chk("stall_addr", mem_if.req_addr, 64'h10);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b1);
    idle(1'b0, 1'b1);
    chk("stall_after_acc", 64'(mem_if.req_valid), 64'h0);

    // Redirect while held -> parked, applied on accept with kill.
    idle(1'b1, 1'b0);
    redir(1'b1, 64'h100, 1'b0);
    idle(1'b1, 1'b0);
    chk("pend_addr", mem_if.req_addr, 64'h14);
    idle(1'b1, 1'b1);
    chk("pend_kill", 64'(fetch_kill_o), 64'h1);
    idle(1'b0, 1'b0);
    chk("pend_new_addr", mem_if.req_addr, 64'h100);

    // Trap beats redirect; parked trap not overwritten by a redirect.
    step(1'b0, 1'b0, 1'b0, 1'b1, 64'h800, 1'b1, 64'h200, 1'b0);
    idle(1'b1, 1'b0);
    chk("trap_prio", pc_out_o, 64'h800);
    step(1'b0, 1'b1, 1'b0, 1'b1, 64'h900, 1'b0, 64'h0, 1'b0);
    redir(1'b1, 64'h300, 1'b0);
    idle(1'b1, 1'b1);
    chk("trap_pend_kill", 64'(fetch_kill_o), 64'h1);
    idle(1'b0, 1'b0);
    chk("trap_kept", pc_out_o, 64'h900);

    // Misaligned redirect and pc wrap.
    redir(1'b0, 64'h102, 1'b0);
    idle(1'b0, 1'b0);
    chk("mis_pc", pc_out_o, 64'h100);
    chk("mis_pulse", 64'(misalign_o), 64'h1);
    idle(1'b0, 1'b0);
    chk("mis_clear", 64'(misalign_o), 64'h0);
    redir(1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    idle(1'b1, 1'b1);
    idle(1'b0, 1'b0);
    chk("wrap", pc_out_o, 64'h0);

    // Halt and restart via redirect.
    step(1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
    idle(1'b1, 1'b1);
    chk("halted", 64'(halted_o), 64'h1);
    chk("halt_valid", 64'(mem_if.req_valid), 64'h0);
    redir(1'b0, 64'h40, 1'b0);
    idle(1'b0, 1'b0);
    chk("unhalt", 64'(halted_o), 64'h0);
    chk("unhalt_pc", pc_out_o, 64'h40);

    // Asynchronous reset in the middle of PEND.
    idle(1'b1, 1'b0);
    redir(1'b1, 64'h80, 1'b0);
    rst = 1'b1;
    #1;
    chk("async_pc", pc_out_o, RV);
    chk("async_valid", 64'(mem_if.req_valid), 64'h0);
    model_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(0, 199) == 0);
      en  = ($urandom_range(0, 3) != 0);
      hq  = ($urandom_range(0, 19) == 0);
      tv  = ($urandom_range(0, 19) == 0);
      rv  = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 4) < 3);
      tp  = {$urandom, $urandom};
      rp  = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) rp = {60'hFFFF_FFFF_FFFF_FFF, 4'(rp)};
      step(r, en, hq, tv, tp, rv, rp, rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
